// File: rtl/usb_crc_pkg.sv
// Shared USB CRC constants, the CRC5 per-bit step, and the crc5_chk state type.
package usb_crc_pkg;

  localparam logic [4:0]  CRC5_POLY      = 5'b00101;
  localparam logic [4:0]  CRC5_INIT      = 5'b11111;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;

  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // {endp[3:0], addr[6:0]}
  localparam int unsigned TOKEN_FIELD_W  = 11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESULT
  } crc5_state_e;

  // One serial step of x^5+x^2+1, MSB-feedback form.
  function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic b);
    logic fb;
    fb = crc[4] ^ b;
    return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
  endfunction

endpackage

// File: rtl/crc5_chk_if.sv
// Token-checker bus: serial bit stream and framing strobes in, result out.
interface crc5_chk_if;
  import usb_crc_pkg::*;

  logic                     pkt_start;
  logic                     bit_in;
  logic                     bit_valid;
  logic                     pkt_end;
  logic                     done;
  logic                     crc_ok;
  logic                     len_err;
  logic [TOKEN_FIELD_W-1:0] token_field;

  modport master (
    output pkt_start, bit_in, bit_valid, pkt_end,
    input  done, crc_ok, len_err, token_field
  );

  modport slave (
    input  pkt_start, bit_in, bit_valid, pkt_end,
    output done, crc_ok, len_err, token_field
  );
endinterface

// File: rtl/crc5_lfsr.sv
// Serial CRC5 register: init loads CRC5_INIT (wins over enable),
// enable advances one bit.
module crc5_lfsr
  import usb_crc_pkg::*;
(
  input  logic       clk,
  input  logic       enable_i,
  input  logic       init_i,
  input  logic       bit_i,
  output logic [4:0] crc_o
);

  logic [4:0] crc_q, crc_d;

  // Next CRC value: load, step, or hold.
  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC5_INIT;
    end else if (enable_i) begin
      crc_d = crc5_step(crc_q, bit_i);
    end
  end

  // CRC state register.
  always_ff @(posedge clk) begin
    crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/crc5_chk.sv
// USB token CRC5 checker. Counts and checks the bits after the PID, flags
// length errors, and reports a one-cycle done pulse after EOP.
// Build option: define CRC5_CHK_FIELD_EN to capture {endp, addr} into
// token_field; otherwise token_field is tied to zero.
module crc5_chk
  import usb_crc_pkg::*;
#(
  parameter int unsigned TOKEN_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  crc5_chk_if.slave  bus
);

  crc5_state_e state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic        crc_ok_q, crc_ok_d;
  logic        len_err_q, len_err_d;
  logic [4:0]  crc;
  logic        start_accept;
  logic        shift_en;
  logic        in_result;
  logic        count_match;
  logic        eval_ok;
  logic        eval_len_err;

  // pkt_start is honoured in IDLE and SHIFT (restart); RESULT always
  // returns to IDLE. A bit arriving with pkt_start belongs to nothing.
  assign start_accept = bus.pkt_start && (state_q != RESULT);
  assign shift_en     = (state_q == SHIFT) && bus.bit_valid && !bus.pkt_start;
  assign in_result    = (state_q == RESULT);

  crc5_lfsr u_lfsr (
    .clk      (clk),
    .enable_i (shift_en),
    .init_i   (rst || start_accept),
    .bit_i    (bus.bit_in),
    .crc_o    (crc)
  );

  // A bit coincident with pkt_end has already been folded into crc/count
  // by the time RESULT is entered, so the evaluation is taken there.
  assign count_match  = (32'(count_q) == TOKEN_BITS);
  assign eval_ok      = (crc == CRC5_RESIDUAL) && count_match;
  assign eval_len_err = !count_match;

  // Next state: start/restart, EOP into RESULT, single-cycle RESULT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.pkt_start) state_d = SHIFT;
      SHIFT: begin
        if (bus.pkt_start)    state_d = SHIFT;
        else if (bus.pkt_end) state_d = RESULT;
      end
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next bit count (saturating) and held result flags.
  always_comb begin
    count_d   = count_q;
    crc_ok_d  = crc_ok_q;
    len_err_d = len_err_q;
    if (start_accept) begin
      count_d   = '0;
      crc_ok_d  = 1'b0;
      len_err_d = 1'b0;
    end else begin
      if (shift_en && (count_q != 5'd31)) begin
        count_d = count_q + 5'd1;
      end
      if (in_result) begin
        crc_ok_d  = eval_ok;
        len_err_d = eval_len_err;
      end
    end
  end

  // State, counter and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      crc_ok_q  <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      crc_ok_q  <= crc_ok_d;
      len_err_q <= len_err_d;
    end
  end

  // Results appear combinationally during RESULT (one cycle after the
  // EOP edge) and are then held by the _q copies until the next start.
  assign bus.done    = in_result;
  assign bus.crc_ok  = in_result ? eval_ok      : crc_ok_q;
  assign bus.len_err = in_result ? eval_len_err : len_err_q;

`ifdef CRC5_CHK_FIELD_EN
  logic [TOKEN_FIELD_W-1:0] token_q, token_d;

  // Token bits 0..10 shift in from the top so bit 0 ends at the LSB.
  always_comb begin
    token_d = token_q;
    if (start_accept) begin
      token_d = '0;
    end else if (shift_en && (count_q < 5'd11)) begin
      token_d = {bus.bit_in, token_q[TOKEN_FIELD_W-1:1]};
    end
  end

  // Captured token field register.
  always_ff @(posedge clk) begin
    if (rst) token_q <= '0;
    else     token_q <= token_d;
  end

  assign bus.token_field = token_q;
`else
  assign bus.token_field = '0;
`endif

endmodule

// File: doc/crc5_chk.md
CRC5_CHK -- requirements
Module: crc5_chk

Interface
REQ-001 SHALL have parameter TOKEN_BITS, default 16, meaning total field bits after PID (11 data plus 5 CRC).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port pkt_start  input  1  one-cycle strobe; the next valid bit is token bit 0.
REQ-005 SHALL have port bit_in  input  1  unstuffed, NRZI-decoded serial bit, in bus (LSB-first) order.
REQ-006 SHALL have port bit_valid  input  1  qualifies bit_in for exactly one cycle.
REQ-007 SHALL have port pkt_end  input  1  one-cycle EOP strobe.
REQ-008 SHALL have port done  output  1  one-cycle pulse; the result is valid.
REQ-009 SHALL have port crc_ok  output  1  residual matched and length correct, held until next pkt_start.
REQ-010 SHALL have port len_err  output  1  bit count not equal to TOKEN_BITS at EOP, held until next pkt_start.
REQ-011 SHALL have port token_field  output  11  captured {endp[3:0], addr[6:0]}, held until next pkt_start.

Function
REQ-012 SHALL implement a serial LFSR with init 5'b11111 and poly x^5+x^2+1.
- Per valid bit: fb = crc[4]^bit_in; crc = {crc[3:0],0} ^ (fb ? 5'b00101 : 0).
REQ-013 SHALL use states IDLE, SHIFT, RESULT.
- IDLE->SHIFT on pkt_start.
- SHIFT->RESULT on pkt_end.
- RESULT->IDLE after exactly one cycle.
REQ-014 SHALL, on pkt_start, load CRC init, clear the 5-bit bit counter, and clear crc_ok, len_err and token_field.
REQ-015 SHALL, in SHIFT with bit_valid, update the LFSR and increment the counter.
- The counter saturates at 31; it does not wrap.
REQ-016 SHALL shift bits 0..10 into token_field LSB-first.
REQ-017 SHALL ignore bit_valid in IDLE and RESULT.
REQ-018 SHALL, when bit_valid and pkt_end occur in the same cycle, include that bit before evaluation.
REQ-019 SHALL, in RESULT, assert done for one cycle.
- crc_ok = (crc == 5'b01100) && (count == TOKEN_BITS).
- len_err = (count != TOKEN_BITS).
REQ-020 SHALL treat pkt_start in SHIFT as abort-and-restart: no done pulse for the aborted packet.
REQ-021 SHALL, when pkt_start and pkt_end coincide in SHIFT, give pkt_start priority (restart, no result).
REQ-022 SHALL ignore pkt_end in IDLE; done is not asserted.
REQ-023 SHALL have latency of one cycle from the pkt_end edge to the done/crc_ok edge.

Reset
REQ-024 SHALL, on rst high at a clk edge, enter IDLE.
- CRC = 5'b11111, counter = 0.
- done, crc_ok, len_err = 0; token_field = 0.
REQ-025 SHALL give rst priority over all inputs; rst mid-packet discards it with no done pulse.

Configuration
REQ-026 SHALL use macro CRC5_CHK_FIELD_EN.
- Defined: token_field capture as in REQ-016.
- Undefined: token_field is driven constant 0 and no capture flops exist.
- All other behaviour is identical in both builds.

Structure
REQ-027 SHALL place the following in shared package usb_crc_pkg, alongside CRC16 constants:
- CRC5_POLY (5'b00101), CRC5_INIT (5'b11111), CRC5_RESIDUAL (5'b01100).
- The crc5_chk state enum.
REQ-028 SHALL factor the per-bit LFSR step into sub-module crc5_lfsr (inputs: enable, init, bit; output: 5-bit crc) so the generator side can reuse it.

Verification
REQ-029 SHALL cover: addr 0x00, endp 0x0, CRC bits 0,1,0,0,0 sent after 11 zeros, then pkt_end.
- Required: done one cycle later, crc_ok=1, len_err=0, token_field=0.
REQ-030 SHALL cover: addr 0x15, endp 0xE, CRC 5'b10111 in bus order.
- Required: crc_ok=1, token_field=11'h715 (CRC5_CHK_FIELD_EN defined).
REQ-031 SHALL cover: the packet of REQ-030 with bit 4 flipped.
- Required: done=1, crc_ok=0, len_err=0.
REQ-032 SHALL cover: 15 valid bits then pkt_end, and separately 17 bits then pkt_end.
- Required: len_err=1 and crc_ok=0 in both cases.
REQ-033 SHALL cover two abort/reset cases:
- pkt_start after 8 bits, then a full valid packet: exactly one done, crc_ok=1.
- rst after 8 bits: all outputs 0 and no done pulse.
REQ-034 SHALL cover: the final bit_valid coincident with pkt_end on the good packet.
- Required: crc_ok=1.
- pkt_end while IDLE yields no done pulse.
